// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller:
// access-type encodings, FSM states and access-size decoding.
package dmem_pkg;

    // bit3 = write, bits[2:0] select size and signedness
    localparam logic [3:0] RW_LB  = 4'b0000;
    localparam logic [3:0] RW_LH  = 4'b0001;
    localparam logic [3:0] RW_LW  = 4'b0010;
    localparam logic [3:0] RW_LBU = 4'b0100;
    localparam logic [3:0] RW_LHU = 4'b0101;
    localparam logic [3:0] RW_SB  = 4'b1000;
    localparam logic [3:0] RW_SH  = 4'b1001;
    localparam logic [3:0] RW_SW  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Any code with bit1 set is treated as a word so stray encodings stay harmless
    function automatic size_t decode_size(input logic [1:0] sz);
        if (sz[1]) begin
            return SZ_WORD;
        end else if (sz[0]) begin
            return SZ_HALF;
        end else begin
            return SZ_BYTE;
        end
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Bundle of pipeline-side and memory-side signals of the access controller.
// The controller uses the slave view; the pipeline/memory environment uses master.
interface dmem_access_ctrl_if;

    logic        mem_valid_i;
    logic [3:0]  rw_sel_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busywait_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misalign_o;
    logic        timeout_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  mem_valid_i, rw_sel_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        output busywait_o, rdata_o, rdata_valid_o, misalign_o, timeout_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output mem_valid_i, rw_sel_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        input  busywait_o, rdata_o, rdata_valid_o, misalign_o, timeout_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane handling: byte enables, store-data alignment, misalignment detection
// for the incoming access, and lane extraction plus extension of returned load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  acc_type,
    input  logic [1:0]  acc_offset,
    input  logic [31:0] acc_data,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misalign,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    size_t       acc_size;
    size_t       ld_size;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        acc_size  = decode_size(acc_type[1:0]);
        be        = 4'b0000;
        misalign  = 1'b0;
        lane_data = acc_data << {acc_offset, 3'b000};
        case (acc_size)
            SZ_BYTE: be = 4'b0001 << acc_offset;
            SZ_HALF: begin
                be       = 4'b0011 << acc_offset;
                misalign = acc_offset[0];
            end
            default: begin
                be       = 4'b1111;
                misalign = |acc_offset;
            end
        endcase
    end

    // ld_type bit2 set means zero-extend, clear means sign-extend
    always_comb begin
        ld_size   = decode_size(ld_type[1:0]);
        byte_lane = ld_word[{ld_offset, 3'b000} +: 8];
        half_lane = ld_word[{ld_offset[1], 4'b0000} +: 16];
        case (ld_size)
            SZ_BYTE: ld_data = ld_type[2] ? {24'h000000, byte_lane}
                                          : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data = ld_type[2] ? {16'h0000, half_lane}
                                          : {{16{half_lane[15]}}, half_lane};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences one data-memory access per load/store held in EX/MEM, stalling the
// pipeline via busywait until the access completes, times out or is rejected.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic               clk_i,
    input logic               rst_i,
    dmem_access_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lat_type;
    logic [1:0]       lat_offset;
    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             rdata_valid_q;
    logic             misalign_q;
    logic             timeout_q;

    logic [3:0]       acc_be;
    logic [31:0]      acc_wdata;
    logic             acc_misalign;
    logic [31:0]      ld_data;

    // Load extraction uses the latched type/offset so the live pipeline inputs may change
    dmem_lane_align u_align (
        .acc_type   (bus.rw_sel_i[2:0]),
        .acc_offset (bus.addr_i[1:0]),
        .acc_data   (bus.wdata_i),
        .be         (acc_be),
        .lane_data  (acc_wdata),
        .misalign   (acc_misalign),
        .ld_type    (lat_type),
        .ld_offset  (lat_offset),
        .ld_word    (bus.mem_rdata_i),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lat_type      <= '0;
            lat_offset    <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.mem_valid_i) begin
                        if (acc_misalign) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state      <= ST_REQ;
                            cnt        <= '0;
                            req_q      <= 1'b1;
                            we_q       <= bus.rw_sel_i[3];
                            addr_q     <= {bus.addr_i[31:2], 2'b00};
                            be_q       <= acc_be;
                            wdata_q    <= acc_wdata;
                            lat_type   <= bus.rw_sel_i[2:0];
                            lat_offset <= bus.addr_i[1:0];
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the final allowed cycle still completes normally
                    if (bus.mem_ack_i) begin
                        state <= ST_DONE;
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q       <= ld_data;
                            rdata_valid_q <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // DONE drops busywait for one cycle so the held instruction leaves EX/MEM
    assign bus.busywait_o    = rst_i & ((state == ST_REQ) |
                               ((state == ST_IDLE) & bus.mem_valid_i & ~acc_misalign));
    assign bus.rdata_o       = rdata_q;
    assign bus.rdata_valid_o = rdata_valid_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.mem_req_o     = req_q;
    assign bus.mem_we_o      = we_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_be_o      = be_q;
    assign bus.mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: transaction-level reference model,
// per-cycle compare process, directed scenarios and randomized accesses.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dmem_access_ctrl_if dif ();

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (7)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic        check_en = 1'b0;
    logic        exp_busy, exp_req, exp_rvalid, exp_mis, exp_to, exp_bus, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        carry_mis;

    int          obs_busy, obs_req, obs_rvalid, obs_mis, obs_to;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    logic [3:0]  codes [8] = '{RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU, RW_SB, RW_SH, RW_SW};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, required, $time);
        end
    endtask

    // Reference rules: size in bytes, alignment, lanes and extension
    function automatic int model_bytes(input logic [3:0] sel);
        case (sel[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_misaligned(input logic [3:0] sel, input logic [31:0] addr);
        return (addr % model_bytes(sel)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input int nb, input logic [1:0] off);
        logic [3:0] m;
        m = 4'((1 << nb) - 1);
        return 4'(m << off);
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] sel, input logic [1:0] off,
                                               input logic [31:0] word);
        int          nb;
        logic [31:0] v, mask;
        nb = model_bytes(sel);
        if (nb == 4) return word;
        v    = word >> (8 * off);
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (!sel[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busywait", 32'(dif.busywait_o), 32'(exp_busy));
            checkOutput("mem_req", 32'(dif.mem_req_o), 32'(exp_req));
            checkOutput("rdata_valid", 32'(dif.rdata_valid_o), 32'(exp_rvalid));
            checkOutput("misalign", 32'(dif.misalign_o), 32'(exp_mis));
            checkOutput("timeout", 32'(dif.timeout_o), 32'(exp_to));
            checkOutput("rdata", dif.rdata_o, exp_rdata);
            if (exp_bus) begin
                checkOutput("mem_we", 32'(dif.mem_we_o), 32'(exp_we));
                checkOutput("mem_addr", dif.mem_addr_o, exp_addr);
                checkOutput("mem_be", 32'(dif.mem_be_o), 32'(exp_be));
                checkOutput("mem_wdata", dif.mem_wdata_o, exp_wdata);
            end
            if (dif.busywait_o) obs_busy++;
            if (dif.rdata_valid_o) obs_rvalid++;
            if (dif.misalign_o) obs_mis++;
            if (dif.timeout_o) obs_to++;
            if (dif.mem_req_o) begin
                obs_req++;
                last_addr  = dif.mem_addr_o;
                last_wdata = dif.mem_wdata_o;
                last_be    = dif.mem_be_o;
                last_we    = dif.mem_we_o;
            end
        end
    end

    task automatic clear_obs();
        obs_busy = 0; obs_req = 0; obs_rvalid = 0; obs_mis = 0; obs_to = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        exp_mis    = carry_mis;
        carry_mis  = 1'b0;
        exp_rvalid = 1'b0;
        exp_to     = 1'b0;
        exp_bus    = 1'b0;
        exp_req    = 1'b0;
        exp_busy   = 1'b0;
        dif.mem_ack_i   = 1'b0;
        dif.mem_rdata_i = $urandom;
    endtask

    task automatic idle_cycle(input logic force_ack);
        next_cycle();
        dif.mem_valid_i = 1'b0;
        dif.rw_sel_i    = 4'($urandom);
        dif.addr_i      = $urandom;
        dif.mem_ack_i   = force_ack | ($urandom_range(0, 3) == 0);
    endtask

    // One instruction: issue, REQ cycles until ack (or timeout), then the release cycle
    task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword,
                                 input int ack_delay);
        logic [1:0] off;
        int         nb;
        bit         acked;
        int         nreq;
        off   = addr[1:0];
        nb    = model_bytes(sel);
        acked = (ack_delay >= 1) && (ack_delay <= TIMEOUT);
        nreq  = acked ? ack_delay : TIMEOUT;
        next_cycle();
        dif.mem_valid_i = 1'b1;
        dif.rw_sel_i    = sel;
        dif.addr_i      = addr;
        dif.wdata_i     = wdata;
        dif.mem_ack_i   = ($urandom_range(0, 3) == 0);
        if (model_misaligned(sel, addr)) begin
            carry_mis = 1'b1;
            return;
        end
        exp_busy = 1'b1;
        for (int k = 1; k <= nreq; k++) begin
            next_cycle();
            dif.rw_sel_i = 4'($urandom);
            dif.addr_i   = $urandom;
            dif.wdata_i  = $urandom;
            exp_busy  = 1'b1;
            exp_req   = 1'b1;
            exp_bus   = 1'b1;
            exp_we    = sel[3];
            exp_addr  = addr & 32'hFFFF_FFFC;
            exp_be    = model_be(nb, off);
            exp_wdata = wdata << (8 * off);
            if (acked && k == nreq) begin
                dif.mem_ack_i   = 1'b1;
                dif.mem_rdata_i = rword;
            end
        end
        next_cycle();
        dif.mem_valid_i = 1'($urandom_range(0, 1));
        dif.rw_sel_i    = 4'($urandom);
        dif.addr_i      = $urandom;
        dif.mem_ack_i   = ($urandom_range(0, 3) == 0);
        if (!acked) begin
            exp_to    = 1'b1;
            exp_rdata = 32'h0;
        end else if (!sel[3]) begin
            exp_rvalid = 1'b1;
            exp_rdata  = model_load(sel, off, rword);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dif.mem_valid_i = 1'b0;
        dif.rw_sel_i    = 4'h0;
        dif.addr_i      = 32'h0;
        dif.wdata_i     = 32'h0;
        dif.mem_ack_i   = 1'b0;
        dif.mem_rdata_i = 32'h0;
        exp_busy = 0; exp_req = 0; exp_rvalid = 0; exp_mis = 0; exp_to = 0;
        exp_bus = 0; exp_we = 0; exp_rdata = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
        carry_mis = 1'b0;
        clear_obs();
        check_en = 1'b1;
        rst_n = 1'b0;
        #2;
        checkOutput("reset_mem_req", 32'(dif.mem_req_o), 32'h0);
        checkOutput("reset_busywait", 32'(dif.busywait_o), 32'h0);
        checkOutput("reset_rdata", dif.rdata_o, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Aligned LW, ack in third request cycle
        clear_obs();
        applyStimulus(RW_LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
        settle();
        checkOutput("t1_busy_cycles", obs_busy, 4);
        checkOutput("t1_rvalid_pulses", obs_rvalid, 1);
        checkOutput("t1_rdata", dif.rdata_o, 32'hDEAD_BEEF);

        // SB into the top byte lane
        clear_obs();
        applyStimulus(RW_SB, 32'h0000_0103, 32'h0000_00A5, 32'h0, 2);
        settle();
        checkOutput("t2_be", 32'(last_be), 32'h8);
        checkOutput("t2_wdata", last_wdata, 32'hA500_0000);
        checkOutput("t2_we", 32'(last_we), 32'h1);
        checkOutput("t2_addr", last_addr, 32'h0000_0100);
        checkOutput("t2_rdata_kept", dif.rdata_o, 32'hDEAD_BEEF);

        // Signed and unsigned halfword from the upper lane
        applyStimulus(RW_LH, 32'h0000_0202, 32'h0, 32'h8001_0000, 1);
        settle();
        checkOutput("t3_lh", dif.rdata_o, 32'hFFFF_8001);
        applyStimulus(RW_LHU, 32'h0000_0202, 32'h0, 32'h8001_0000, 2);
        settle();
        checkOutput("t3_lhu", dif.rdata_o, 32'h0000_8001);

        // Misaligned word is rejected without a stall or request
        clear_obs();
        applyStimulus(RW_LW, 32'h0000_0101, 32'h0, 32'h0, 1);
        idle_cycle(1'b0);
        settle();
        checkOutput("t4_misalign_pulses", obs_mis, 1);
        checkOutput("t4_req_cycles", obs_req, 0);
        checkOutput("t4_busy_cycles", obs_busy, 0);

        // No ack: timeout, then a late ack must be ignored
        clear_obs();
        applyStimulus(RW_LW, 32'h0000_0400, 32'h0, 32'h0, 0);
        settle();
        checkOutput("t5_timeout_pulses", obs_to, 1);
        checkOutput("t5_busy_cycles", obs_busy, TIMEOUT + 1);
        checkOutput("t5_rdata", dif.rdata_o, 32'h0);
        idle_cycle(1'b1);
        settle();
        checkOutput("t5_late_ack_timeout", obs_to, 1);
        checkOutput("t5_late_ack_rvalid", obs_rvalid, 0);

        // Ack in the very last allowed cycle wins over the timeout
        clear_obs();
        applyStimulus(RW_LW, 32'h0000_0500, 32'h0, 32'h1234_5678, TIMEOUT);
        settle();
        checkOutput("edge_ack_timeout", obs_to, 0);
        checkOutput("edge_ack_rdata", dif.rdata_o, 32'h1234_5678);

        // Reset in the middle of an outstanding request
        next_cycle();
        dif.mem_valid_i = 1'b1;
        dif.rw_sel_i    = RW_LW;
        dif.addr_i      = 32'h0000_0300;
        dif.wdata_i     = 32'h0;
        exp_busy = 1'b1;
        repeat (2) begin
            next_cycle();
            exp_busy = 1'b1; exp_req = 1'b1; exp_bus = 1'b1;
            exp_we = 1'b0; exp_addr = 32'h0000_0300; exp_be = 4'hF; exp_wdata = 32'h0;
        end
        settle();
        rst_n = 1'b0;
        dif.mem_valid_i = 1'b0;
        exp_busy = 0; exp_req = 0; exp_bus = 0; exp_rdata = 32'h0; carry_mis = 1'b0;
        #1;
        checkOutput("t6_req_drop", 32'(dif.mem_req_o), 32'h0);
        checkOutput("t6_busywait", 32'(dif.busywait_o), 32'h0);
        checkOutput("t6_rdata", dif.rdata_o, 32'h0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        rst_n = 1'b1;
        applyStimulus(RW_LBU, 32'h0000_0303, 32'h0, 32'hAB00_0000, 1);
        settle();
        checkOutput("t6_after_reset_lbu", dif.rdata_o, 32'h0000_00AB);

        // Randomized accesses across all access types, offsets and ack delays
        for (int i = 0; i < 300; i++) begin
            int r;
            int delay;
            r = $urandom_range(0, 99);
            if (r < 5) delay = 0;
            else if (r < 10) delay = $urandom_range(TIMEOUT - 4, TIMEOUT);
            else delay = $urandom_range(1, 5);
            applyStimulus(codes[$urandom_range(0, 7)], $urandom, $urandom, $urandom, delay);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'b0);
        end
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
